// File: rtl/lfsr_bank.sv
// Multi-channel Galois LFSR uniform source with seed load, zero guard, valid/ready output and sample counter.
// Optional build macro LFSR_LEAP_EN: each advance applies LEAP steps instead of one.
module lfsr_bank #(
  parameter int                 WIDTH     = 32,
  parameter int                 CHANNELS  = 4,
  parameter logic [WIDTH-1:0]   TAPS      = WIDTH'(32'h80200003),
  parameter logic [31:0]        SEED_SALT = 32'h9E3779B9,
  parameter int                 CNT_W     = 16,
  parameter int                 LEAP      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          seed,
  input  logic                      write,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] numout,
  output logic                      out_valid,
  output logic [CNT_W-1:0]          sample_cnt
);

`ifdef LFSR_LEAP_EN
  localparam int ADV_STEPS = LEAP;
`else
  // LEAP has no effect in the single-step build.
  localparam int ADV_STEPS = (LEAP > 0) ? 1 : 1;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, PRIME, RUN} fsm_e;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] lfsr_advance(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] r;
    r = s;
    for (int k = 0; k < ADV_STEPS; k++) begin
      r = lfsr_step(r);
    end
    return r;
  endfunction

  // An all-zero register would lock up, so that seed is replaced by all-ones.
  function automatic logic [WIDTH-1:0] chan_seed(input logic [WIDTH-1:0] sd, input int idx);
    logic [WIDTH-1:0] salt;
    logic [WIDTH-1:0] c;
    salt = WIDTH'(SEED_SALT);
    c    = sd ^ (salt * WIDTH'(idx));
    return (c == '0) ? '1 : c;
  endfunction

  fsm_e                      fsm_q, fsm_d;
  logic [WIDTH-1:0]          state_q [CHANNELS];
  logic [WIDTH-1:0]          state_d [CHANNELS];
  logic [WIDTH-1:0]          seed_c  [CHANNELS];
  logic [WIDTH-1:0]          adv_c   [CHANNELS];
  logic [CHANNELS*WIDTH-1:0] numout_q, numout_d;
  logic [CHANNELS*WIDTH-1:0] adv_packed;
  logic                      out_valid_q, out_valid_d;
  logic [CNT_W-1:0]          sample_cnt_q, sample_cnt_d;

  always_comb begin
    adv_packed = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      seed_c[ch] = chan_seed(seed, ch);
      adv_c[ch]  = lfsr_advance(state_q[ch]);
      adv_packed[ch*WIDTH +: WIDTH] = adv_c[ch];
    end
  end

  // A write in any state reloads every channel; it overrides a handshake in RUN.
  always_comb begin
    fsm_d        = fsm_q;
    state_d      = state_q;
    numout_d     = numout_q;
    out_valid_d  = out_valid_q;
    sample_cnt_d = sample_cnt_q;
    case (fsm_q)
      IDLE: begin
        out_valid_d = 1'b0;
        if (write) begin
          state_d = seed_c;
          fsm_d   = LOAD;
        end
      end
      LOAD: begin
        out_valid_d = 1'b0;
        if (write) begin
          state_d = seed_c;
        end else begin
          fsm_d = PRIME;
        end
      end
      PRIME: begin
        if (write) begin
          state_d     = seed_c;
          out_valid_d = 1'b0;
          fsm_d       = LOAD;
        end else begin
          state_d      = adv_c;
          numout_d     = adv_packed;
          out_valid_d  = 1'b1;
          sample_cnt_d = '0;
          fsm_d        = RUN;
        end
      end
      RUN: begin
        if (write) begin
          state_d     = seed_c;
          out_valid_d = 1'b0;
          fsm_d       = LOAD;
        end else if (out_valid_q && out_ready) begin
          state_d      = adv_c;
          numout_d     = adv_packed;
          sample_cnt_d = sample_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        out_valid_d = 1'b0;
        fsm_d       = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q        <= IDLE;
      numout_q     <= '0;
      out_valid_q  <= 1'b0;
      sample_cnt_q <= '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        state_q[ch] <= '1;
      end
    end else begin
      fsm_q        <= fsm_d;
      numout_q     <= numout_d;
      out_valid_q  <= out_valid_d;
      sample_cnt_q <= sample_cnt_d;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        state_q[ch] <= state_d[ch];
      end
    end
  end

  assign numout     = numout_q;
  assign out_valid  = out_valid_q;
  assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_lfsr_bank.sv
// Self-checking bench for lfsr_bank (default build): directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the generator.
module tb_lfsr_bank;

  localparam int          W     = 32;
  localparam int          NCH   = 4;
  localparam logic [31:0] TAPSV = 32'h80200003;
  localparam logic [31:0] SALTV = 32'h9E3779B9;

  logic             clk;
  logic             rst;
  logic [W-1:0]     seed;
  logic             write;
  logic             outReady;
  logic [NCH*W-1:0] numout;
  logic             outValid;
  logic [15:0]      sampleCnt;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model: phase 0 idle, 1 seeded, 2 priming, 3 streaming.
  int          mPhase;
  logic [31:0] mState [NCH];
  logic [31:0] mNum   [NCH];
  bit          mValid;
  int          mCnt;

  lfsr_bank dut (
    .clk       (clk),
    .rst       (rst),
    .seed      (seed),
    .write     (write),
    .out_ready (outReady),
    .numout    (numout),
    .out_valid (outValid),
    .sample_cnt(sampleCnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] refStep(input logic [31:0] s);
    if (s % 2 == 1) return (s / 2) ^ TAPSV;
    return s / 2;
  endfunction

  function automatic logic [31:0] refSeed(input logic [31:0] sd, input int idx);
    longint unsigned prod;
    logic [31:0] c;
    prod = longint'(idx) * longint'(SALTV);
    c = sd ^ prod[31:0];
    if (c == 0) c = 32'hFFFFFFFF;
    return c;
  endfunction

  function automatic void reseedModel(input logic [31:0] sd);
    for (int i = 0; i < NCH; i++) mState[i] = refSeed(sd, i);
  endfunction

  function automatic void advanceModel();
    for (int i = 0; i < NCH; i++) begin
      mState[i] = refStep(mState[i]);
      mNum[i]   = mState[i];
    end
  endfunction

  function automatic void modelEdge(input bit r, input bit w, input logic [31:0] sd, input bit rdy);
    if (r) begin
      mPhase = 0; mValid = 0; mCnt = 0;
      for (int i = 0; i < NCH; i++) begin
        mState[i] = 32'hFFFFFFFF;
        mNum[i]   = 0;
      end
    end else if (w) begin
      reseedModel(sd);
      mValid = 0;
      mPhase = 1;
    end else if (mPhase == 1) begin
      mPhase = 2;
    end else if (mPhase == 2) begin
      advanceModel();
      mValid = 1;
      mCnt   = 0;
      mPhase = 3;
    end else if (mPhase == 3 && rdy) begin
      advanceModel();
      mCnt = (mCnt + 1) % 65536;
    end
  endfunction

  function automatic logic [NCH*W-1:0] modelNum();
    logic [NCH*W-1:0] p;
    for (int i = 0; i < NCH; i++) p[i*W +: W] = mNum[i];
    return p;
  endfunction

  task automatic checkOutput(input string tag, input logic [NCH*W-1:0] observed,
                             input logic [NCH*W-1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic compareModel();
    checkOutput("out_valid", {{(NCH*W-1){1'b0}}, outValid}, {{(NCH*W-1){1'b0}}, mValid});
    checkOutput("sample_cnt", {{(NCH*W-16){1'b0}}, sampleCnt}, (NCH*W)'(mCnt));
    checkOutput("numout", numout, modelNum());
  endtask

  task automatic applyStimulus(input bit r, input bit w, input logic [31:0] sd, input bit rdy);
    rst      = r;
    write    = w;
    seed     = sd;
    outReady = rdy;
    @(posedge clk);
    modelEdge(r, w, sd, rdy);
    #1;
    compareModel();
  endtask

  initial begin
    logic [NCH*W-1:0] heldNum;
    int cntBefore;
    bit rw, rr, rrdy;
    logic [31:0] rs;

    rst = 1'b1; write = 1'b0; seed = '0; outReady = 1'b0;
    mPhase = 0; mValid = 0; mCnt = 0;
    for (int i = 0; i < NCH; i++) begin
      mState[i] = 32'hFFFFFFFF;
      mNum[i]   = 0;
    end

    $display("[TB] reset");
    applyStimulus(1, 0, 32'h0, 0);
    applyStimulus(1, 0, 32'h0, 0);
    checkOutput("rst_numout", numout, '0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 32'h0, 1);
    checkOutput("idle_valid", {{(NCH*W-1){1'b0}}, outValid}, '0);

    $display("[TB] seed load");
    applyStimulus(0, 1, 32'h12324a6f, 1);
    applyStimulus(0, 0, 32'h0, 1);
    checkOutput("prime_pending", {{(NCH*W-1){1'b0}}, outValid}, '0);
    applyStimulus(0, 0, 32'h0, 1);
    checkOutput("seed_ch0", (NCH*W)'(numout[31:0]), (NCH*W)'(32'h89392534));
    checkOutput("seed_valid", {{(NCH*W-1){1'b0}}, outValid}, (NCH*W)'(1));
    applyStimulus(0, 0, 32'h0, 1);
    checkOutput("hs_ch0", (NCH*W)'(numout[31:0]), (NCH*W)'(32'h449C929A));
    checkOutput("hs_cnt", (NCH*W)'(sampleCnt), (NCH*W)'(1));

    $display("[TB] zero guard");
    applyStimulus(0, 1, 32'h0, 0);
    applyStimulus(0, 0, 32'h0, 0);
    applyStimulus(0, 0, 32'h0, 0);
    checkOutput("zero_ch0", (NCH*W)'(numout[31:0]), (NCH*W)'(32'hFFDFFFFC));
    checkOutput("zero_ch1", (NCH*W)'(numout[63:32]), (NCH*W)'(32'hCF3BBCDF));

    $display("[TB] backpressure");
    applyStimulus(0, 0, 32'h0, 1);
    applyStimulus(0, 0, 32'h0, 1);
    heldNum   = modelNum();
    cntBefore = mCnt;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 32'h0, 0);
      checkOutput("stall_numout", numout, heldNum);
      checkOutput("stall_cnt", (NCH*W)'(sampleCnt), (NCH*W)'(cntBefore));
    end
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 32'h0, 1);
    checkOutput("resume_cnt", (NCH*W)'(sampleCnt), (NCH*W)'(cntBefore + 4));

    $display("[TB] reseed during handshake");
    cntBefore = mCnt;
    applyStimulus(0, 1, 32'hCAFEF00D, 1);
    checkOutput("reseed_valid", {{(NCH*W-1){1'b0}}, outValid}, '0);
    checkOutput("reseed_cnt", (NCH*W)'(sampleCnt), (NCH*W)'(cntBefore));
    applyStimulus(0, 0, 32'h0, 1);
    applyStimulus(0, 0, 32'h0, 1);
    checkOutput("reseed_ch0", (NCH*W)'(numout[31:0]), (NCH*W)'(refStep(32'hCAFEF00D)));

    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      rr   = ($urandom_range(0, 299) == 0);
      rw   = ($urandom_range(0, 19) == 0);
      rrdy = ($urandom_range(0, 1) == 1);
      rs   = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      applyStimulus(rr, rw, rs, rrdy);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
